pixel_cell_divider: RTL and testbench
=====================================

Name: pixel_cell_divider

Overview:
- Sequential, parametrised pixel-to-grid converter for the VGA/Tetris datapath.
- Takes an (x, y) pixel coordinate and returns the board cell (col, row), the intra-cell pixel offsets, and an out-of-board flag.
- Uses a shared-FSM restoring divider, one quotient bit per clock, with both axes computed in parallel.
- Valid/ready handshakes on input and output, so it sits between the VGA pixel/mouse coordinate source and the board-lookup logic.

Parameters:
- W, 10: width of coordinates, quotients and remainders.
- DIVISOR, 20: cell side in pixels. Legal range 1 .. 2^W-1. Illegal value is an elaboration error.
- COLS, 10: board width in cells.
- ROWS, 20: board height in cells.
- CLAMP, 0: 0 reports the raw quotient. 1 saturates out-of-board quotients to COLS-1 / ROWS-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  coordinate request valid
- in_ready  out  1  block can accept a request
- in_x  in  W  pixel x
- in_y  in  W  pixel y
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_col  out  W  x / DIVISOR (clamped if CLAMP=1)
- out_row  out  W  y / DIVISOR (clamped if CLAMP=1)
- out_col_rem  out  W  x mod DIVISOR
- out_row_rem  out  W  y mod DIVISOR
- out_oor  out  1  raw col >= COLS or raw row >= ROWS

Behaviour:
- FSM states: IDLE, CALC, DONE. rst asynchronously forces IDLE, clears all result registers and the bit counter. out_valid=0 and all result outputs=0 during and after reset.
- in_ready = (state==IDLE) && !rst. It is a combinational decode of state only, with no dependence on in_valid.
- IDLE: when in_valid && in_ready on an edge, capture in_x/in_y, clear the partial remainders, load the bit counter with W-1, and go to CALC.
- CALC: on each edge, for each axis, do one restoring step:
  - rem' = {rem, next dividend MSB}
  - if rem' >= DIVISOR: subtract DIVISOR and shift in quotient bit 1; else shift in 0.
  - Internal remainder width is W+1 bits, so no overflow is possible.
  - After the step with counter==0, the results register and state goes to DONE.
  - Exactly W edges are spent in CALC. out_valid rises W cycles after the accepting edge.
- DONE: out_valid=1 and outputs are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE. out_valid drops the following cycle.
  - No new request is accepted in DONE. Sustained throughput is one result per W+2 cycles.
- Arithmetic is exact floor division with remainder in 0..DIVISOR-1. A coordinate equal to k*DIVISOR maps to cell k with remainder 0.
- out_oor is computed from the raw quotients.
  - CLAMP=1: out_col = min(raw, COLS-1) and out_row = min(raw, ROWS-1). Remainders are never altered.
- in_x/in_y changing after acceptance have no effect on the in-flight result.
- rst mid-CALC or mid-DONE: the in-flight request is discarded, with no output pulse. in_ready=1 on the first cycle after rst deasserts.
- DIVISOR=1: quotient = input, remainder = 0, same W-cycle latency.

Test Plan:
1. Defaults, x=0, y=0 → col 0, row 0, rems 0, oor 0; out_valid exactly 10 cycles after accept.
2. x=19, y=20 → col 0 rem 19, row 1 rem 0; x=20, y=39 → col 1 rem 0, row 1 rem 19. This covers the exact boundaries.
3. x=199, y=399 → col 9 rem 19, row 19 rem 19, oor 0. x=200, y=0 with CLAMP=0 → col 10, oor 1. The same input with CLAMP=1 → col 9 rem 0, oor 1.
4. x=1023, y=1023 (CLAMP=0) → col 51 rem 3, row 51 rem 3, oor 1. Sweep all x 0..1023 against a reference model.
5. Backpressure: hold out_ready=0 for 7 cycles with in_valid held high → outputs stable, in_ready=0 throughout. Releasing out_ready gives one handshake, in_ready=1 the next cycle, and the next request is accepted.
6. Assert rst 4 cycles into CALC → out_valid never pulses, all outputs 0, and in_ready=1 the cycle after release. A subsequent x=45, y=61 gives col 2 rem 5, row 3 rem 1.

Source files
------------

// File: rtl/pixel_cell_divider.sv
// Pixel-to-board-cell converter: restoring division of x and y by the cell size,
// one quotient bit per clock on both axes, with valid/ready on both sides.
module pixel_cell_divider #(
   parameter int W       = 10,
   parameter int DIVISOR = 20,
   parameter int COLS    = 10,
   parameter int ROWS    = 20,
   parameter int CLAMP   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_col,
   output logic [W-1:0] out_row,
   output logic [W-1:0] out_col_rem,
   output logic [W-1:0] out_row_rem,
   output logic         out_oor
);

   if (W < 2 || W > 30 || DIVISOR < 1 || DIVISOR > (2 ** W) - 1) begin : gBadParams
      $error("pixel_cell_divider: DIVISOR must lie in 1 .. 2**W-1 (W in 2..30)");
   end

   localparam int CW = $clog2(W);
   localparam logic [W:0]    DIV_EXT  = (W + 1)'(DIVISOR);
   localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
   localparam logic [31:0]   COLS_U   = 32'(COLS);
   localparam logic [31:0]   ROWS_U   = 32'(ROWS);
   localparam logic [W-1:0]  COL_MAX  = W'(COLS - 1);
   localparam logic [W-1:0]  ROW_MAX  = W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;
   stateT state, stateNext;

   logic [CW-1:0] bitCnt;
   logic [W-1:0]  divX, divY;
   logic [W-1:0]  remX, remY;
   logic [W:0]    trialX, trialY;
   logic          geX, geY;
   logic [W-1:0]  divXNext, divYNext;
   logic [W-1:0]  remXNext, remYNext;
   logic          accept, lastStep;
   logic          oorNext;
   logic [W-1:0]  colFinal, rowFinal;

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   // Control decode: handshake acceptance, the final division step and DONE release.
   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      lastStep  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept    = 1'b1;
               stateNext = CALC;
            end
         end
         CALC: begin
            if (bitCnt == '0) begin
               lastStep  = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            if (out_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // One restoring step per axis; quotient bits shift into the dividend register's LSB,
   // so after W steps the dividend register holds the quotient.
   always_comb begin
      trialX   = {remX, divX[W-1]};
      trialY   = {remY, divY[W-1]};
      geX      = (trialX >= DIV_EXT);
      geY      = (trialY >= DIV_EXT);
      remXNext = geX ? W'(trialX - DIV_EXT) : trialX[W-1:0];
      remYNext = geY ? W'(trialY - DIV_EXT) : trialY[W-1:0];
      divXNext = {divX[W-2:0], geX};
      divYNext = {divY[W-2:0], geY};
      oorNext  = (32'(divXNext) >= COLS_U) || (32'(divYNext) >= ROWS_U);
      colFinal = divXNext;
      rowFinal = divYNext;
      if (CLAMP != 0 && 32'(divXNext) >= COLS_U) colFinal = COL_MAX;
      if (CLAMP != 0 && 32'(divYNext) >= ROWS_U) rowFinal = ROW_MAX;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Datapath: capture on accept, iterate in CALC, register the results on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitCnt      <= '0;
         divX        <= '0;
         divY        <= '0;
         remX        <= '0;
         remY        <= '0;
         out_col     <= '0;
         out_row     <= '0;
         out_col_rem <= '0;
         out_row_rem <= '0;
         out_oor     <= 1'b0;
      end else if (accept) begin
         divX   <= in_x;
         divY   <= in_y;
         remX   <= '0;
         remY   <= '0;
         bitCnt <= CNT_LOAD;
      end else if (state == CALC) begin
         divX <= divXNext;
         divY <= divYNext;
         remX <= remXNext;
         remY <= remYNext;
         if (lastStep) begin
            out_col     <= colFinal;
            out_row     <= rowFinal;
            out_col_rem <= remXNext;
            out_row_rem <= remYNext;
            out_oor     <= oorNext;
         end else begin
            bitCnt <= bitCnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_cell_divider.sv
// Drives three converters (raw, clamped, unit divisor) in lockstep and checks
// them against integer-division expectations queued at acceptance time.
module tb_pixel_cell_divider;

   localparam int W = 10;

   typedef struct packed {
      logic [2:0][W-1:0] col;
      logic [2:0][W-1:0] row;
      logic [2:0][W-1:0] colRem;
      logic [2:0][W-1:0] rowRem;
      logic [2:0]        oor;
   } expT;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_x, in_y;
   logic [2:0]   ir, ov, oOor;
   logic [W-1:0] oCol [3];
   logic [W-1:0] oRow [3];
   logic [W-1:0] oColRem [3];
   logic [W-1:0] oRowRem [3];

   expT expQ[$];
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;

   pixel_cell_divider #(.W(W), .DIVISOR(20), .COLS(10), .ROWS(20), .CLAMP(0)) dutRaw (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_x(in_x), .in_y(in_y),
      .out_valid(ov[0]), .out_ready(out_ready), .out_col(oCol[0]), .out_row(oRow[0]),
      .out_col_rem(oColRem[0]), .out_row_rem(oRowRem[0]), .out_oor(oOor[0]));

   pixel_cell_divider #(.W(W), .DIVISOR(20), .COLS(10), .ROWS(20), .CLAMP(1)) dutClamp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_x(in_x), .in_y(in_y),
      .out_valid(ov[1]), .out_ready(out_ready), .out_col(oCol[1]), .out_row(oRow[1]),
      .out_col_rem(oColRem[1]), .out_row_rem(oRowRem[1]), .out_oor(oOor[1]));

   pixel_cell_divider #(.W(W), .DIVISOR(1), .COLS(10), .ROWS(20), .CLAMP(0)) dutUnit (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_x(in_x), .in_y(in_y),
      .out_valid(ov[2]), .out_ready(out_ready), .out_col(oCol[2]), .out_row(oRow[2]),
      .out_col_rem(oColRem[2]), .out_row_rem(oRowRem[2]), .out_oor(oOor[2]));

   // Reference: plain floor division per instance configuration.
   function automatic expT buildExp(input int x, input int y);
      expT e;
      int div, c, r;
      for (int d = 0; d < 3; d++) begin
         div         = (d == 2) ? 1 : 20;
         c           = x / div;
         r           = y / div;
         e.oor[d]    = (c >= 10) || (r >= 20);
         e.colRem[d] = W'(x % div);
         e.rowRem[d] = W'(y % div);
         e.col[d]    = W'((d == 1 && c > 9) ? 9 : c);
         e.row[d]    = W'((d == 1 && r > 19) ? 19 : r);
      end
      return e;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkFields(input string tag, input expT e);
      for (int d = 0; d < 3; d++) begin
         checkValue($sformatf("%s d%0d col", tag, d),     32'(oCol[d]),    32'(e.col[d]));
         checkValue($sformatf("%s d%0d row", tag, d),     32'(oRow[d]),    32'(e.row[d]));
         checkValue($sformatf("%s d%0d colRem", tag, d), 32'(oColRem[d]), 32'(e.colRem[d]));
         checkValue($sformatf("%s d%0d rowRem", tag, d), 32'(oRowRem[d]), 32'(e.rowRem[d]));
         checkValue($sformatf("%s d%0d oor", tag, d),    32'(oOor[d]),    32'(e.oor[d]));
      end
   endtask

   // Present a request, wait for acceptance, optionally queue its expectation,
   // then scramble the inputs so later changes cannot leak into the result.
   task automatic applyStimulus(input int x, input int y, input bit pushExp);
      int guard = 0;
      in_valid = 1'b1;
      in_x     = W'(x);
      in_y     = W'(y);
      while (ir !== 3'b111 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) checkValue("accept timeout", 32'(ir), 32'd7);
      if (pushExp) expQ.push_back(buildExp(x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_x     = W'($urandom);
      in_y     = W'($urandom);
   endtask

   // Wait for the result, check latency and contents, optionally stall, then handshake.
   task automatic checkOutput(input int hold);
      int   cycles = 0;
      expT  e;
      checkValue("in_ready low in CALC", 32'(ir), 32'd0);
      while (ov !== 3'b111 && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkValue("latency", 32'(cycles), 32'(W));
      if (expQ.size() == 0) begin
         checkValue("scoreboard empty", 32'd0, 32'd1);
         e = '0;
      end else begin
         e = expQ.pop_front();
      end
      checkFields("result", e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkValue("hold out_valid", 32'(ov), 32'd7);
         checkValue("hold in_ready", 32'(ir), 32'd0);
         checkFields("hold", e);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkValue("out_valid after handshake", 32'(ov), 32'd0);
      checkValue("in_ready after handshake", 32'(ir), 32'd7);
   endtask

   initial begin
      int pulses;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_y      = '0;
      #1;
      checkValue("reset out_valid", 32'(ov), 32'd0);
      checkValue("reset in_ready", 32'(ir), 32'd0);
      checkFields("reset", '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkValue("in_ready after reset", 32'(ir), 32'd7);

      $display("[TB] directed boundaries");
      applyStimulus(0, 0, 1);       checkOutput(0);
      applyStimulus(19, 20, 1);     checkOutput(0);
      applyStimulus(20, 39, 1);     checkOutput(0);
      applyStimulus(199, 399, 1);   checkOutput(0);
      applyStimulus(200, 0, 1);     checkOutput(0);
      applyStimulus(1023, 1023, 1); checkOutput(0);

      $display("[TB] x sweep");
      for (int x = 0; x < 1024; x++) begin
         applyStimulus(x, int'($urandom_range(0, 1023)), 1);
         checkOutput(0);
      end

      $display("[TB] backpressure");
      applyStimulus(100, 150, 1);
      in_valid = 1'b1;
      in_x     = W'(300);
      in_y     = W'(5);
      checkOutput(7);
      applyStimulus(300, 5, 1);
      checkOutput(0);

      $display("[TB] reset during CALC");
      applyStimulus(500, 500, 0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkValue("mid reset out_valid", 32'(ov), 32'd0);
      checkFields("mid reset", '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkValue("in_ready after mid reset", 32'(ir), 32'd7);
      pulses = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk); #1;
         if (ov != 3'b000) pulses++;
      end
      checkValue("no pulse after reset", 32'(pulses), 32'd0);
      applyStimulus(45, 61, 1);
      checkOutput(0);

      checkValue("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
